// File: rtl/braille_pkg.sv
// Shared types and constants for the BCD digit streamer that feeds the Braille encoder.
package braille_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        STREAM  = 2'd2
    } state_e;

    localparam int         BCD_W       = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_VAL    = 4'd3;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: adds 3 to any BCD digit of 5 or more before the shift.
module bcd_add3
    import braille_pkg::*;
(
    input  logic [BCD_W-1:0] nib_in,
    output logic [BCD_W-1:0] nib_out
);

    always_comb begin
        nib_out = (nib_in >= ADD3_THRESH) ? (nib_in + ADD3_VAL) : nib_in;
    end

endmodule

// File: rtl/bcd_digit_streamer.sv
// Binary to BCD conversion (one bit per cycle) followed by MSD-first digit streaming
// with leading-zero suppression over a valid/ready handshake.
module bcd_digit_streamer
    import braille_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bin_in,
    input  logic             start,
    output logic             busy,
    output logic [3:0]       BCD,
    output logic             digit_valid,
    input  logic             digit_ready,
    output logic             last_digit,
    output logic             done
);

    localparam int BCD_FW = DIGITS * BCD_W;
    localparam int SH_W   = BCD_FW + WIDTH;
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int PTR_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_digits_too_few
        $error("bcd_digit_streamer: DIGITS too small to hold 2**WIDTH-1");
    end

    state_e             state_q, state_d;
    logic [SH_W-1:0]    sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;

    logic [BCD_FW-1:0]  bcd_fix;
    logic [SH_W-1:0]    sh_shift;
    logic [PTR_W-1:0]   msd_idx;
    logic [PTR_W-1:0]   ptr_dec;
    logic [BCD_W-1:0]   cur_digit;
    logic [BCD_W-1:0]   next_digit;
    logic               last_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_in  (sh_q[WIDTH + g*BCD_W +: BCD_W]),
            .nib_out (bcd_fix[g*BCD_W +: BCD_W])
        );
    end

    always_comb begin
        sh_shift   = {bcd_fix[BCD_FW-2:0], sh_q[WIDTH-1:0], 1'b0};
        last_shift = (cnt_q == CNT_W'(1));
        ptr_dec    = ptr_q - PTR_W'(1);
        cur_digit  = sh_q[WIDTH + int'(ptr_q)*BCD_W +: BCD_W];
        next_digit = sh_q[WIDTH + int'(ptr_dec)*BCD_W +: BCD_W];
    end

    // Highest nonzero digit wins; an all-zero value falls back to digit 0.
    always_comb begin
        msd_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sh_shift[WIDTH + i*BCD_W +: BCD_W] != '0) begin
                msd_idx = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONVERT;
            CONVERT: if (last_shift) state_d = STREAM;
            STREAM:  if (valid_q && digit_ready && last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d   = {{BCD_FW{1'b0}}, bin_in};
                    cnt_d  = CNT_W'(WIDTH);
                    ptr_d  = '0;
                    busy_d = 1'b1;
                end
            end
            CONVERT: begin
                sh_d  = sh_shift;
                cnt_d = cnt_q - CNT_W'(1);
                if (last_shift) begin
                    ptr_d = msd_idx;
                end
            end
            STREAM: begin
                // First STREAM cycle presents the leading digit; afterwards each
                // transfer advances to the next digit without a bubble.
                if (!valid_q) begin
                    valid_d = 1'b1;
                    bcd_d   = cur_digit;
                    last_d  = (ptr_q == '0);
                end else if (digit_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        bcd_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d  = ptr_dec;
                        bcd_d  = next_digit;
                        last_d = (ptr_dec == '0);
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                bcd_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy        = busy_q;
    assign BCD         = bcd_q;
    assign digit_valid = valid_q;
    assign last_digit  = last_q;
    assign done        = done_q;

endmodule

// File: tb/tb_bcd_digit_streamer.sv
// Randomized self-checking bench: expected digit sequences come from decimal arithmetic on each value.
module tb_bcd_digit_streamer;

    localparam int WIDTH  = 10;
    localparam int DIGITS = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] bin_in = '0;
    logic             start = 1'b0;
    logic             busy;
    logic [3:0]       BCD;
    logic             digit_valid;
    logic             digit_ready = 1'b1;
    logic             last_digit;
    logic             done;

    int n_checks = 0;
    int n_fails  = 0;
    int exp_q[$];
    int n_xfer = 0;
    bit mon_en = 1'b0;
    bit exp_done = 1'b0;
    bit prev_stall = 1'b0;
    int prev_bcd = 0;
    int prev_last = 0;
    int rdy_mode = 0;
    int stall_cnt = 0;

    bcd_digit_streamer #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .bin_in      (bin_in),
        .start       (start),
        .busy        (busy),
        .BCD         (BCD),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .last_digit  (last_digit),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decimal digits of v, most significant first, leading zeros dropped.
    task automatic push_digits(input int v);
        int d[$];
        int x;
        x = v;
        if (x == 0) d.push_back(0);
        while (x > 0) begin
            d.push_front(x % 10);
            x = x / 10;
        end
        foreach (d[i]) exp_q.push_back(d[i]);
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: digit_ready = 1'b1;
            1: digit_ready = 1'($urandom_range(0, 1));
            default: begin
                if (digit_valid && stall_cnt < 3) begin
                    digit_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    digit_ready = 1'b1;
                end
            end
        endcase
    end

    always @(negedge clk) begin
        int e;
        if (mon_en) begin
            if (prev_stall) begin
                check("hold_vld", int'(digit_valid), 1);
                check("hold_bcd", int'(BCD), prev_bcd);
                check("hold_last", int'(last_digit), prev_last);
            end
            check("done_pulse", int'(done), int'(exp_done));
            exp_done = 1'b0;
            if (!digit_valid) check("bcd_when_idle", int'(BCD), 0);
            else check("bcd_range", int'(BCD <= 4'd9), 1);
            if (digit_valid && digit_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    check("xfer_extra", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("digit", int'(BCD), e);
                    check("last_flag", int'(last_digit), (exp_q.size() == 0) ? 1 : 0);
                    if (exp_q.size() == 0) exp_done = 1'b1;
                end
            end
            prev_stall = digit_valid && !digit_ready;
            prev_bcd   = int'(BCD);
            prev_last  = int'(last_digit);
        end
    end

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            tick();
            if (done) break;
        end
        if (i == budget) check("done_timeout", 0, 1);
    endtask

    task automatic run_number(input int value);
        int j;
        int n_exp;
        n_xfer = 0;
        n_exp  = exp_q.size();
        push_digits(value);
        n_exp  = exp_q.size() - n_exp;
        bin_in = WIDTH'(value);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        bin_in = WIDTH'($urandom);
        check("busy_after_start", int'(busy), 1);
        for (j = 1; j < 50; j++) begin
            tick();
            if (digit_valid) break;
        end
        check("first_latency", j, WIDTH + 1);
        wait_done(300);
        check("busy_after_done", int'(busy), 0);
        check("xfer_count", n_xfer, n_exp);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_last(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (digit_valid && last_digit) break;
            tick();
        end
        if (i == budget) check("last_timeout", 0, 1);
    endtask

    initial begin
        // Reset held with start asserted: nothing may begin.
        reset  = 1'b1;
        start  = 1'b1;
        bin_in = WIDTH'(123);
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_busy", int'(busy), 0);
            check("rst_valid", int'(digit_valid), 0);
            check("rst_done", int'(done), 0);
            check("rst_bcd", int'(BCD), 0);
            check("rst_last", int'(last_digit), 0);
        end
        reset = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("post_rst_busy", int'(busy), 0);
            check("post_rst_valid", int'(digit_valid), 0);
        end
        mon_en = 1'b1;

        rdy_mode = 0;
        run_number(1023);
        tick();
        check("done_one_cycle", int'(done), 0);
        run_number(0);
        run_number(7);
        run_number(407);
        run_number(1000);
        run_number(10);

        rdy_mode = 2;
        stall_cnt = 0;
        run_number(58);
        rdy_mode = 0;

        // Starts during CONVERT and on the final transfer are ignored.
        n_xfer = 0;
        push_digits(12);
        bin_in = WIDTH'(12);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (3) tick();
        bin_in = WIDTH'(999);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_last(50);
        bin_in = WIDTH'(999);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("done_after_12", int'(done), 1);
        check("busy_after_12", int'(busy), 0);
        check("xfer_12", n_xfer, 2);
        check("queue_12", exp_q.size(), 0);
        // Start on the done cycle is accepted.
        run_number(999);

        // Reset mid-stream after the first digit of 1023 moved.
        n_xfer = 0;
        push_digits(1023);
        bin_in = WIDTH'(1023);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (n_xfer >= 1) break;
            tick();
        end
        check("mid_first_xfer", n_xfer, 1);
        mon_en     = 1'b0;
        prev_stall = 1'b0;
        exp_done   = 1'b0;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(digit_valid), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_bcd", int'(BCD), 0);
        check("mid_rst_last", int'(last_digit), 0);
        exp_q.delete();
        tick();
        mon_en = 1'b1;
        run_number(45);

        rdy_mode = 1;
        for (int r = 0; r < 20; r++) begin
            run_number(int'($urandom_range(0, 1023)));
        end

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
